// File: rtl/reg_file_multiport_pkg.sv
// Shared definitions for the register-file family: clear-sweep state encoding
// and the entry-count derivation used by every memory block sized by address width.
package reg_file_multiport_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_t;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/reg_file_sweep_ctrl.sv
// Background clear sequencer: walks a pointer over every entry, one per cycle,
// and pulses DONE the cycle after the last entry has been cleared.
module reg_file_sweep_ctrl
   import reg_file_multiport_pkg::*;
#(
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CLEAR,
   output sweep_state_t      STATE,
   output logic [ADDR_W-1:0] PTR,
   output logic              DONE
);

   localparam int DEPTH = depth_of(ADDR_W);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   sweep_state_t      state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              done_q, done_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         done_q  <= done_d;
      end
   end

   // CLEAR is only looked at in IDLE, so a request during a sweep never restarts it.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (CLEAR) begin
               state_d = ST_SWEEP;
               ptr_d   = '0;
            end
         end
         ST_SWEEP: begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == LAST_PTR) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign STATE = state_q;
   assign PTR   = ptr_q;
   assign DONE  = done_q;

endmodule

// File: rtl/reg_file_multiport.sv
// Multi-read-port register file for the datapath: one synchronous write port,
// NUM_RD combinational read ports, optional zero register, bypass and clear sweep.
module reg_file_multiport
   import reg_file_multiport_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 0
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [DATA_W-1:0]        IN,
   input  logic [ADDR_W-1:0]        INADDRESS,
   input  logic                     WRITE,
   input  logic [NUM_RD*ADDR_W-1:0] OUTADDRESS,
   output logic [NUM_RD*DATA_W-1:0] OUT,
   input  logic                     CLEAR,
   output logic                     BUSY,
   output logic                     DONE
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];
   sweep_state_t      sweep_state;
   logic [ADDR_W-1:0] sweep_ptr;
   logic              write_acc;
   logic              write_ok;

   reg_file_sweep_ctrl #(
      .ADDR_W (ADDR_W)
   ) u_sweep (
      .CLK   (CLK),
      .RESET (RESET),
      .CLEAR (CLEAR),
      .STATE (sweep_state),
      .PTR   (sweep_ptr),
      .DONE  (DONE)
   );

   assign BUSY      = (sweep_state == ST_SWEEP);
   assign write_acc = WRITE & ~RESET & ~BUSY;
   // A write aimed at the hardwired zero entry is dropped here, so bypass never sees it either.
   assign write_ok  = write_acc & ~((ZERO_REG != 0) && (INADDRESS == '0));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (BUSY) begin
         mem[sweep_ptr] <= '0;
      end else if (write_ok) begin
         mem[INADDRESS] <= IN;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] raddr;
      logic [DATA_W-1:0] rdata;

      assign raddr = OUTADDRESS[k*ADDR_W +: ADDR_W];

      always_comb begin
         rdata = mem[raddr];
         if ((BYPASS != 0) && write_ok && (raddr == INADDRESS)) begin
            rdata = IN;
         end
         if ((ZERO_REG != 0) && (raddr == '0)) begin
            rdata = '0;
         end
      end

      assign OUT[k*DATA_W +: DATA_W] = rdata;
   end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Bench for reg_file_multiport: a default instance, a bypass/zero-register instance
// and a wide four-port instance, checked through an expected-value queue.
module tb_reg_file_multiport;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // instance A: defaults (BYPASS=0, ZERO_REG=0)
   logic [7:0]  a_in;
   logic [2:0]  a_waddr;
   logic        a_we;
   logic [5:0]  a_raddr;
   logic [15:0] a_out;
   logic        a_clear, a_busy, a_done;

   // instance B: BYPASS=1, ZERO_REG=1
   logic [7:0]  b_in;
   logic [2:0]  b_waddr;
   logic        b_we;
   logic [5:0]  b_raddr;
   logic [15:0] b_out;
   logic        b_clear, b_busy, b_done;

   // instance C: DATA_W=16, ADDR_W=4, NUM_RD=4
   logic [15:0] c_in;
   logic [3:0]  c_waddr;
   logic        c_we;
   logic [15:0] c_raddr;
   logic [63:0] c_out;
   logic        c_clear, c_busy, c_done;

   reg_file_multiport u_a (
      .CLK(clk), .RESET(rst), .IN(a_in), .INADDRESS(a_waddr), .WRITE(a_we),
      .OUTADDRESS(a_raddr), .OUT(a_out), .CLEAR(a_clear), .BUSY(a_busy), .DONE(a_done)
   );

   reg_file_multiport #(.ZERO_REG(1), .BYPASS(1)) u_b (
      .CLK(clk), .RESET(rst), .IN(b_in), .INADDRESS(b_waddr), .WRITE(b_we),
      .OUTADDRESS(b_raddr), .OUT(b_out), .CLEAR(b_clear), .BUSY(b_busy), .DONE(b_done)
   );

   reg_file_multiport #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) u_c (
      .CLK(clk), .RESET(rst), .IN(c_in), .INADDRESS(c_waddr), .WRITE(c_we),
      .OUTADDRESS(c_raddr), .OUT(c_out), .CLEAR(c_clear), .BUSY(c_busy), .DONE(c_done)
   );

   int checks = 0;
   int failures = 0;
   logic [15:0] exp_q[$];

   typedef struct {
      logic       we;
      logic [2:0] wa;
      logic [7:0] wd;
      logic [2:0] ra0;
      logic [2:0] ra1;
      logic [7:0] e0;
      logic [7:0] e1;
   } vec_t;

   vec_t vecs[8];

   task automatic expect_val(input logic [15:0] e);
      exp_q.push_back(e);
   endtask

   task automatic check_next(input string name, input logic [15:0] act);
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: got %h, no expected value queued", name, act);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, e);
         end
      end
   endtask

   task automatic a_write(input logic [2:0] addr, input logic [7:0] data);
      @(negedge clk);
      a_we = 1'b1; a_waddr = addr; a_in = data;
      @(negedge clk);
      a_we = 1'b0;
   endtask

   task automatic c_write(input logic [3:0] addr, input logic [15:0] data);
      @(negedge clk);
      c_we = 1'b1; c_waddr = addr; c_in = data;
      @(negedge clk);
      c_we = 1'b0;
   endtask

   task automatic a_check_all(input string tag, input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         a_raddr = {3'(7 - i), 3'(i)};
         #1;
         expect_val(v); check_next($sformatf("%s_p0_r%0d", tag, i), a_out[7:0]);
         expect_val(v); check_next($sformatf("%s_p1_r%0d", tag, 7 - i), a_out[15:8]);
      end
   endtask

   // Assumes every entry of A holds 8'hFF; abort_at < 0 lets the sweep run to completion.
   task automatic a_sweep(input int abort_at, input string tag);
      int  busy_cnt = 0;
      bit  finished = 1'b0;
      bit  done_seen = 1'b0;
      @(negedge clk);
      a_clear = 1'b1;
      @(negedge clk);
      a_clear = 1'b0;
      for (int i = 0; i < 20 && !finished; i++) begin
         #1;
         if (a_busy) begin
            a_raddr = {3'(busy_cnt), (busy_cnt == 0) ? 3'd0 : 3'(busy_cnt - 1)};
            #1;
            expect_val((busy_cnt == 0) ? 16'h00FF : 16'h0000);
            check_next($sformatf("%s_prev_cleared_%0d", tag, busy_cnt), a_out[7:0]);
            expect_val(16'h00FF);
            check_next($sformatf("%s_ahead_intact_%0d", tag, busy_cnt), a_out[15:8]);
            busy_cnt++;
            a_we    = (busy_cnt == 6);
            a_waddr = 3'd0;
            a_in    = 8'h77;
            a_clear = (busy_cnt == 4);
            rst     = (busy_cnt == abort_at);
         end else begin
            a_we = 1'b0; a_clear = 1'b0; rst = 1'b0;
            done_seen = a_done;
            finished  = 1'b1;
         end
         @(negedge clk);
      end
      a_we = 1'b0; a_clear = 1'b0; rst = 1'b0;
      expect_val(16'd1);
      check_next({tag, "_sweep_ended"}, 16'(finished));
      expect_val((abort_at < 0) ? 16'd8 : 16'(abort_at));
      check_next({tag, "_busy_cycles"}, 16'(busy_cnt));
      expect_val((abort_at < 0) ? 16'd1 : 16'd0);
      check_next({tag, "_done_at_end"}, 16'(done_seen));
      #1;
      expect_val(16'd0);
      check_next({tag, "_done_one_cycle"}, 16'(a_done));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_in = '0; a_waddr = '0; a_we = 1'b0; a_raddr = '0; a_clear = 1'b0;
      b_in = '0; b_waddr = '0; b_we = 1'b0; b_raddr = '0; b_clear = 1'b0;
      c_in = '0; c_waddr = '0; c_we = 1'b0; c_raddr = '0; c_clear = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Random contents, then a single reset edge must wipe everything.
      repeat (6) a_write(3'($urandom_range(0, 7)), 8'($urandom_range(1, 255)));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      expect_val(16'd0); check_next("rst_a_busy", 16'(a_busy));
      expect_val(16'd0); check_next("rst_a_done", 16'(a_done));
      expect_val(16'd0); check_next("rst_b_busy", 16'(b_busy));
      expect_val(16'd0); check_next("rst_c_busy", 16'(c_busy));
      a_check_all("rst", 8'h00);

      // Same-cycle reads show pre-write contents (no bypass on A).
      vecs[0] = '{we: 1'b1, wa: 3'd2, wd: 8'd95,  ra0: 3'd2, ra1: 3'd1, e0: 8'd0,   e1: 8'd0};
      vecs[1] = '{we: 1'b1, wa: 3'd1, wd: 8'd28,  ra0: 3'd2, ra1: 3'd1, e0: 8'd95,  e1: 8'd0};
      vecs[2] = '{we: 1'b0, wa: 3'd0, wd: 8'd0,   ra0: 3'd2, ra1: 3'd1, e0: 8'd95,  e1: 8'd28};
      vecs[3] = '{we: 1'b1, wa: 3'd7, wd: 8'hA5,  ra0: 3'd7, ra1: 3'd7, e0: 8'd0,   e1: 8'd0};
      vecs[4] = '{we: 1'b1, wa: 3'd0, wd: 8'h11,  ra0: 3'd7, ra1: 3'd0, e0: 8'hA5,  e1: 8'd0};
      vecs[5] = '{we: 1'b1, wa: 3'd2, wd: 8'h3C,  ra0: 3'd2, ra1: 3'd0, e0: 8'd95,  e1: 8'h11};
      vecs[6] = '{we: 1'b0, wa: 3'd0, wd: 8'd0,   ra0: 3'd2, ra1: 3'd1, e0: 8'h3C,  e1: 8'd28};
      vecs[7] = '{we: 1'b0, wa: 3'd0, wd: 8'd0,   ra0: 3'd0, ra1: 3'd7, e0: 8'h11,  e1: 8'hA5};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         a_we = vecs[i].we; a_waddr = vecs[i].wa; a_in = vecs[i].wd;
         a_raddr = {vecs[i].ra1, vecs[i].ra0};
         #1;
         expect_val(16'(vecs[i].e0)); check_next($sformatf("vec%0d_p0", i), a_out[7:0]);
         expect_val(16'(vecs[i].e1)); check_next($sformatf("vec%0d_p1", i), a_out[15:8]);
      end
      @(negedge clk);
      a_we = 1'b0;

      // Full sweep with ignored CLEAR and ignored WRITE to r0 while busy.
      for (int i = 0; i < 8; i++) a_write(3'(i), 8'hFF);
      a_check_all("fill", 8'hFF);
      a_sweep(-1, "sweep");
      a_check_all("swept", 8'h00);

      // Reset during the sweep, then a fresh sweep must start from entry 0.
      for (int i = 0; i < 8; i++) a_write(3'(i), 8'hFF);
      a_sweep(3, "abort");
      a_check_all("aborted", 8'h00);
      for (int i = 0; i < 8; i++) a_write(3'(i), 8'hFF);
      a_sweep(-1, "restart");

      // WRITE and CLEAR together, with CLEAR held past DONE.
      @(negedge clk);
      a_we = 1'b1; a_waddr = 3'd5; a_in = 8'h3C; a_clear = 1'b1;
      @(negedge clk);
      a_we = 1'b0;
      a_raddr = {3'd0, 3'd5};
      #1;
      expect_val(16'd1);   check_next("wc_busy", 16'(a_busy));
      expect_val(16'h3C);  check_next("wc_written", a_out[7:0]);
      begin
         bit got_done = 1'b0;
         for (int i = 0; i < 20 && !got_done; i++) begin
            @(negedge clk);
            #1;
            got_done = a_done;
         end
         expect_val(16'd1); check_next("wc_done_seen", 16'(got_done));
      end
      expect_val(16'h00);  check_next("wc_cleared", a_out[7:0]);
      @(negedge clk);
      #1;
      expect_val(16'd1);   check_next("held_clear_restart", 16'(a_busy));
      a_clear = 1'b0;
      for (int i = 0; i < 20 && a_busy; i++) begin
         @(negedge clk);
         #1;
      end
      expect_val(16'd0);   check_next("held_clear_idle", 16'(a_busy));

      // Bypass and zero register on B.
      @(negedge clk);
      b_we = 1'b1; b_waddr = 3'd4; b_in = 8'd6; b_raddr = {3'd1, 3'd4};
      #1;
      expect_val(16'd6); check_next("byp_same_cycle", b_out[7:0]);
      expect_val(16'd0); check_next("byp_other_port", b_out[15:8]);
      @(negedge clk);
      b_we = 1'b0;
      #1;
      expect_val(16'd6); check_next("byp_stored", b_out[7:0]);
      @(negedge clk);
      b_we = 1'b1; b_waddr = 3'd0; b_in = 8'd50; b_raddr = {3'd0, 3'd0};
      #1;
      expect_val(16'd0); check_next("zero_same_cycle", b_out[7:0]);
      @(negedge clk);
      b_we = 1'b0;
      #1;
      expect_val(16'd0); check_next("zero_after", b_out[15:8]);
      @(negedge clk);
      b_we = 1'b1; b_waddr = 3'd3; b_in = 8'h81; b_raddr = {3'd3, 3'd3};
      #1;
      expect_val(16'h81); check_next("byp_both_p0", b_out[7:0]);
      expect_val(16'h81); check_next("byp_both_p1", b_out[15:8]);
      @(negedge clk);
      b_we = 1'b0; b_clear = 1'b1;
      @(negedge clk);
      b_clear = 1'b0;
      b_we = 1'b1; b_waddr = 3'd7; b_in = 8'h5A; b_raddr = {3'd7, 3'd7};
      #1;
      expect_val(16'h00); check_next("byp_blocked_busy", b_out[7:0]);
      @(negedge clk);
      b_we = 1'b0;

      // Wide instance C: all four ports on the same and mixed addresses.
      c_write(4'd15, 16'hBEEF);
      c_raddr = {4{4'd15}};
      #1;
      for (int k = 0; k < 4; k++) begin
         expect_val(16'hBEEF); check_next($sformatf("wide_same_p%0d", k), c_out[k*16 +: 16]);
      end
      c_write(4'd3, 16'h1234);
      c_raddr = {4'd3, 4'd15, 4'd3, 4'd15};
      #1;
      for (int k = 0; k < 4; k++) begin
         expect_val((k % 2 == 0) ? 16'hBEEF : 16'h1234);
         check_next($sformatf("wide_mixed_p%0d", k), c_out[k*16 +: 16]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
